// File: rtl/neuron_sched.sv
// Neuron-update scheduler: sweeps every (core, neuron) pair, fetching parameters,
// handing them to the neuron datapath and writing the resulting spike bit back.
module neuron_sched #(
  parameter int NUM_CORES   = 2,
  parameter int NUM_NEURONS = 256,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          param_rd_en_o,
  output logic [CW-1:0] param_core_o,
  output logic [7:0]    param_addr_o,
  output logic          nc_valid_o,
  input  logic          nc_ready_i,
  input  logic          nc_done_i,
  input  logic          nc_spike_i,
  output logic          omem_we_o,
  output logic [CW-1:0] omem_core_o,
  output logic [7:0]    omem_addr_o,
  output logic          omem_bit_o,
  output logic [15:0]   spike_cnt_o
);

  localparam logic [7:0]    LAST_N = 8'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    WRITE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] core_q, core_d;
  logic [7:0]    neuron_q, neuron_d;
  logic          spike_q, spike_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          busy_q, done_q, rd_en_q, valid_q, we_q, obit_q;
  logic [CW-1:0] pcore_q, ocore_q;
  logic [7:0]    paddr_q, oaddr_q;

  // Next-state, counter advance and spike accounting
  always_comb begin
    state_d  = state_q;
    core_d   = core_q;
    neuron_d = neuron_q;
    spike_d  = spike_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = FETCH;
          core_d   = {CW{1'b0}};
          neuron_d = 8'd0;
          cnt_d    = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = ISSUE;
      ISSUE: begin
        if (nc_ready_i) state_d = WAIT_DONE;
        else            state_d = ISSUE;
      end
      WAIT_DONE: begin
        if (nc_done_i) begin
          state_d = WRITE;
          spike_d = nc_spike_i;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WRITE: begin
        if (spike_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        else                                cnt_d = cnt_q;
        if (neuron_q != LAST_N) begin
          neuron_d = neuron_q + 8'd1;
          state_d  = FETCH;
        end else if (core_q != LAST_C) begin
          neuron_d = 8'd0;
          core_d   = core_q + CW'(1'b1);
          state_d  = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and latched spike
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      core_q   <= {CW{1'b0}};
      neuron_q <= 8'd0;
      spike_q  <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      core_q   <= core_d;
      neuron_q <= neuron_d;
      spike_q  <= spike_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are decoded from the next state so each strobe is a flop aligned with its state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      pcore_q <= {CW{1'b0}};
      paddr_q <= 8'd0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      ocore_q <= {CW{1'b0}};
      oaddr_q <= 8'd0;
      obit_q  <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
      rd_en_q <= (state_d == FETCH);
      pcore_q <= (state_d == FETCH) ? core_d : {CW{1'b0}};
      paddr_q <= (state_d == FETCH) ? neuron_d : 8'd0;
      valid_q <= (state_d == ISSUE);
      we_q    <= (state_d == WRITE);
      ocore_q <= (state_d == WRITE) ? core_q : {CW{1'b0}};
      oaddr_q <= (state_d == WRITE) ? neuron_q : 8'd0;
      obit_q  <= (state_d == WRITE) ? spike_d : 1'b0;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign param_rd_en_o = rd_en_q;
  assign param_core_o  = pcore_q;
  assign param_addr_o  = paddr_q;
  assign nc_valid_o    = valid_q;
  assign omem_we_o     = we_q;
  assign omem_core_o   = ocore_q;
  assign omem_addr_o   = oaddr_q;
  assign omem_bit_o    = obit_q;
  assign spike_cnt_o   = cnt_q;

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of neuron cores swept per run.
REQ-002 SHALL have parameter NUM_NEURONS, default 256: neurons per core; SHALL be a power of two, at most 256.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start_i, input, 1 bit: single-cycle run request.
REQ-006 SHALL have port busy_o, output, 1 bit: high while a run is in progress.
REQ-007 SHALL have port done_o, output, 1 bit: single-cycle pulse when a run completes.
REQ-008 SHALL have port param_rd_en_o, output, 1 bit: parameter SRAM read strobe; read data is valid one cycle later.
REQ-009 SHALL have port param_core_o, output, CW bits: core select for parameter reads, with CW = max(1, ceil(log2 NUM_CORES)).
REQ-010 SHALL have port param_addr_o, output, 8 bits: neuron index for parameter reads.
REQ-011 SHALL have port nc_valid_o, output, 1 bit: request to the neuron datapath that parameters are present.
REQ-012 SHALL have port nc_ready_i, input, 1 bit: datapath accepts the request.
REQ-013 SHALL have port nc_done_i, input, 1 bit: datapath result valid.
REQ-014 SHALL have port nc_spike_i, input, 1 bit: spike result, qualified by nc_done_i.
REQ-015 SHALL have port omem_we_o, output, 1 bit: output spike memory write strobe.
REQ-016 SHALL have port omem_core_o, output, CW bits: core select for output spike writes.
REQ-017 SHALL have port omem_addr_o, output, 8 bits: neuron index for output spike writes.
REQ-018 SHALL have port omem_bit_o, output, 1 bit: spike bit to write.
REQ-019 SHALL have port spike_cnt_o, output, 16 bits: number of spikes in the current or last run.

Function
REQ-020 SHALL implement the states IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_DONE, WRITE and FINISH.
REQ-021 In IDLE, start_i=1 SHALL clear both counters and spike_cnt_o, then go to FETCH; start_i in any other state SHALL be ignored.
REQ-022 FETCH SHALL assert param_rd_en_o for exactly one cycle with param_core_o = core counter and param_addr_o = neuron counter, then go to WAIT_DATA.
REQ-023 WAIT_DATA SHALL last exactly one cycle, then go to ISSUE.
REQ-024 ISSUE SHALL hold nc_valid_o=1 until nc_ready_i=1 is sampled, then go to WAIT_DONE; nc_valid_o SHALL drop in the cycle after acceptance.
REQ-025 WAIT_DONE SHALL wait for nc_done_i=1 and latch nc_spike_i in that cycle, with no timeout.
REQ-026 nc_done_i outside WAIT_DONE SHALL be ignored, including when it is coincident with nc_ready_i in ISSUE.
REQ-027 WRITE SHALL assert omem_we_o for exactly one cycle with omem_core_o/omem_addr_o = current counters and omem_bit_o = the latched spike.
REQ-028 In WRITE, spike_cnt_o SHALL increment if the latched spike is 1 and SHALL saturate at 16'hFFFF.
REQ-029 Counter advance in WRITE: if neuron < NUM_NEURONS-1, neuron SHALL increment and the state SHALL go to FETCH.
REQ-030 Counter advance in WRITE: else if core < NUM_CORES-1, neuron SHALL wrap to 0, core SHALL increment, and the state SHALL go to FETCH.
REQ-031 Counter advance in WRITE: else the state SHALL go to FINISH.
REQ-032 FINISH SHALL assert done_o for one cycle and then return to IDLE; a start_i in the following cycle SHALL begin a new run.
REQ-033 busy_o SHALL be 1 in every state except IDLE.
REQ-034 Strobe outputs SHALL be registered and mutually exclusive: at most one of param_rd_en_o, nc_valid_o, omem_we_o, done_o SHALL be high in any cycle.
REQ-035 With nc_ready_i and nc_done_i tied high, each neuron SHALL take exactly 5 cycles.
REQ-036 With nc_ready_i and nc_done_i tied high and start_i sampled at edge k: FETCH of neuron (0,0) SHALL occur in cycle k+1, its write in cycle k+5, the last write in cycle k+5·NUM_CORES·NUM_NEURONS, and done_o in the cycle after that.
REQ-037 spike_cnt_o SHALL hold its value after a run until the next accepted start_i.

Reset
REQ-038 wb_rst_i=1 SHALL, at the next edge and in any state, force IDLE, clear the counters and spike_cnt_o, and drive all outputs to 0.
REQ-039 A run aborted by reset SHALL NOT produce done_o and SHALL NOT issue any further omem_we_o.

Verification
REQ-040 Scenario: ready/done tied high, default parameters, datapath returns spike = neuron[0] -> 512 writes in order (0,0)…(1,255), omem_bit_o alternating 0,1, spike_cnt_o=256, done_o exactly 2561 cycles after start.
REQ-041 Scenario: nc_ready_i delayed 3 cycles and nc_done_i delayed 4 cycles -> nc_valid_o held 4 cycles, 12 cycles per neuron, no duplicate or skipped addresses.
REQ-042 Scenario: start_i pulsed during a run and nc_done_i pulsed in IDLE/ISSUE -> no effect on sequence, counts or done_o.
REQ-043 Scenario: wb_rst_i asserted at neuron (1,17) WAIT_DONE -> next cycle IDLE, all outputs 0, no done_o; a new start restarts from (0,0) with spike_cnt_o=0.
REQ-044 Scenario: NUM_CORES=1, NUM_NEURONS=4, all spikes 1 -> 4 writes at addresses 0..3, spike_cnt_o=4, done_o at k+21.
REQ-045 Scenario: done_o asserted and start_i raised in the next cycle -> new run accepted, spike_cnt_o cleared to 0.
